// File: rtl/titan_ctrl_pkg.sv
// rtl/titan_ctrl_pkg.sv - shared PC-select codes and sequencer state encoding
package titan_ctrl_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_TRAP   = 2'd2;
  localparam logic [1:0] PC_SEL_XRET   = 2'd3;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/titan_hazard_detect.sv
// rtl/titan_hazard_detect.sv - load-use comparator between the ID sources and the EX load
module titan_hazard_detect (
  input  logic       i_ex_mem_ex_sel,
  input  logic       i_ex_we,
  input  logic [4:0] i_ex_waddr,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_waddr);
  assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_waddr);
  // x0 is hardwired to zero, so a load targeting it never forwards anything
  assign o_load_use = i_ex_mem_ex_sel && i_ex_we && (i_ex_waddr != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/titan_pipeline_ctrl.sv
// rtl/titan_pipeline_ctrl.sv - stall/flush/PC-select sequencer for the five-stage core
module titan_pipeline_ctrl
  import titan_ctrl_pkg::*;
#(
  parameter int FENCE_DRAIN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_waddr,
  input  logic       ex_we,
  input  logic       ex_mem_ex_sel,
  input  logic       ex_branch_taken,
  input  logic       ex_trap_valid,
  input  logic       ex_xret_op,
  input  logic       ex_fence_op,
  input  logic       if_busy,
  input  logic       mem_busy,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       exmem_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic [1:0] pc_sel,
  output logic       fence_active
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FENCE_DRAIN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load_use;
  logic             w_redirect;

  titan_hazard_detect u_hazard (
    .i_ex_mem_ex_sel (ex_mem_ex_sel),
    .i_ex_we         (ex_we),
    .i_ex_waddr      (ex_waddr),
    .i_id_rs1        (id_rs1),
    .i_id_rs2        (id_rs2),
    .i_id_use_rs1    (id_use_rs1),
    .i_id_use_rs2    (id_use_rs2),
    .o_load_use      (w_load_use)
  );

  assign w_redirect = ex_trap_valid || ex_xret_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!mem_busy) begin
            if (w_redirect) begin
              r_state <= ST_REDIRECT;
            end else if (ex_fence_op) begin
              r_state <= ST_DRAIN;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_DRAIN: begin
          if (!mem_busy) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else             r_state <= ST_RUN;
          end
        end
        ST_REDIRECT: r_state <= ST_RUN;
        default:     r_state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    pc_sel       = PC_SEL_SEQ;
    fence_active = 1'b0;
    // Bubbles everywhere while held in reset, before any clock edge
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_flush  = 1'b1;
      fence_active = (r_state == ST_DRAIN);
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pc_sel      = ex_trap_valid ? PC_SEL_TRAP : PC_SEL_XRET;
          end else if (ex_fence_op) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_flush  = 1'b1;
            fence_active = 1'b1;
          end else if (w_load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_sel     = PC_SEL_BRANCH;
          end else if (if_busy) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          // cnt==0 is the release cycle: the fence advances with no control asserted
          if (r_cnt != '0) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_flush  = 1'b1;
            fence_active = 1'b1;
          end
        end
        ST_REDIRECT: ifid_flush = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_titan_pipeline_ctrl.sv
// tb/tb_titan_pipeline_ctrl.sv - directed vector bench for titan_pipeline_ctrl
module tb_titan_pipeline_ctrl;

  localparam logic [7:0] F_BUSY  = 8'h80;
  localparam logic [7:0] F_TRAP  = 8'h40;
  localparam logic [7:0] F_XRET  = 8'h20;
  localparam logic [7:0] F_FENCE = 8'h10;
  localparam logic [7:0] F_BR    = 8'h08;
  localparam logic [7:0] F_IFB   = 8'h04;
  localparam logic [7:0] F_SEL   = 8'h02;
  localparam logic [7:0] F_WE    = 8'h01;

  localparam logic [10:0] O_PCS  = 11'h400;
  localparam logic [10:0] O_IFS  = 11'h200;
  localparam logic [10:0] O_IDS  = 11'h100;
  localparam logic [10:0] O_EXS  = 11'h080;
  localparam logic [10:0] O_IFF  = 11'h040;
  localparam logic [10:0] O_IDF  = 11'h020;
  localparam logic [10:0] O_EXF  = 11'h010;
  localparam logic [10:0] O_MWF  = 11'h008;
  localparam logic [10:0] O_SEL1 = 11'h002;
  localparam logic [10:0] O_SEL2 = 11'h004;
  localparam logic [10:0] O_SEL3 = 11'h006;
  localparam logic [10:0] O_FA   = 11'h001;

  localparam logic [10:0] ROW1  = O_PCS | O_IFS | O_IDS | O_EXS | O_MWF;
  localparam logic [10:0] ROW3  = O_PCS | O_IFS | O_IDS | O_EXF | O_FA;
  localparam logic [10:0] TRAPO = O_IFF | O_IDF | O_EXF;
  localparam logic [10:0] LDUSE = O_PCS | O_IFS | O_IDF;
  localparam logic [10:0] RSTO  = O_IFF | O_IDF | O_EXF | O_MWF;

  typedef struct {
    logic [7:0]  fl;
    logic [4:0]  wa;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        u1;
    logic        u2;
    logic [10:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_waddr;
  logic       id_use_rs1, id_use_rs2, ex_we, ex_mem_ex_sel, ex_branch_taken;
  logic       ex_trap_valid, ex_xret_op, ex_fence_op, if_busy, mem_busy;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, fence_active;
  logic [1:0] pc_sel;

  int n_total = 0;
  int n_pass  = 0;
  int fa_cycles;
  vec_t tbl[$];

  titan_pipeline_ctrl #(.FENCE_DRAIN(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_mem_ex_sel(ex_mem_ex_sel),
    .ex_branch_taken(ex_branch_taken), .ex_trap_valid(ex_trap_valid),
    .ex_xret_op(ex_xret_op), .ex_fence_op(ex_fence_op),
    .if_busy(if_busy), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .pc_sel(pc_sel), .fence_active(fence_active)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] fl, input logic [4:0] wa, input logic [4:0] r1,
                              input logic [4:0] r2, input logic u1, input logic u2,
                              input logic [10:0] exp);
    vec_t v;
    v.fl = fl; v.wa = wa; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2; v.exp = exp;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
            exmem_flush, memwb_flush, pc_sel, fence_active};
  endfunction

  task automatic drive(input vec_t v);
    mem_busy        = v.fl[7];
    ex_trap_valid   = v.fl[6];
    ex_xret_op      = v.fl[5];
    ex_fence_op     = v.fl[4];
    ex_branch_taken = v.fl[3];
    if_busy         = v.fl[2];
    ex_mem_ex_sel   = v.fl[1];
    ex_we           = v.fl[0];
    ex_waddr        = v.wa;
    id_rs1          = v.r1;
    id_rs2          = v.r2;
    id_use_rs1      = v.u1;
    id_use_rs2      = v.u2;
  endtask

  task automatic check(input string name, input int idx, input logic [10:0] exp);
    logic [10:0] got;
    got = outs();
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
  endtask

  // Drive a vector just after a rising edge, check mid-cycle, then advance one clock
  task automatic step(input string name, input int idx, input vec_t v);
    drive(v);
    #2;
    check(name, idx, v.exp);
    if (fence_active === 1'b1) fa_cycles++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    #2;
    check("reset_hold", 0, RSTO);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl.push_back(mk(8'h00,          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    tbl.push_back(mk(F_SEL|F_WE,     5'd5, 5'd0, 5'd5, 1'b0, 1'b1, LDUSE));
    tbl.push_back(mk(8'h00,          5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 11'h0));
    tbl.push_back(mk(F_SEL|F_WE,     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 11'h0));
    tbl.push_back(mk(F_SEL|F_WE,     5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 11'h0));
    tbl.push_back(mk(F_SEL|F_WE,     5'd5, 5'd5, 5'd9, 1'b0, 1'b1, 11'h0));
    tbl.push_back(mk(F_SEL,          5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 11'h0));
    tbl.push_back(mk(F_WE,           5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 11'h0));
    tbl.push_back(mk(F_SEL|F_WE,     5'd9, 5'd9, 5'd0, 1'b1, 1'b0, LDUSE));
    tbl.push_back(mk(F_BR|F_IFB,     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_IFF|O_IDF|O_SEL1));
    tbl.push_back(mk(F_IFB,          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_PCS|O_IFF));
    tbl.push_back(mk(F_BUSY|F_BR|F_SEL|F_WE, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, ROW1));
    tbl.push_back(mk(F_BR|F_SEL|F_WE, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, LDUSE));
    tbl.push_back(mk(F_TRAP|F_XRET,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, TRAPO|O_SEL2));
    tbl.push_back(mk(F_BR|F_IFB,     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_IFF));
    tbl.push_back(mk(F_XRET,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, TRAPO|O_SEL3));
    tbl.push_back(mk(F_BUSY,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW1));
    tbl.push_back(mk(8'h00,          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    tbl.push_back(mk(F_FENCE,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW3));
    tbl.push_back(mk(F_TRAP|F_BR,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW3));
    tbl.push_back(mk(F_FENCE,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    tbl.push_back(mk(8'h00,          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));

    fa_cycles = 0;
    for (int i = 0; i < tbl.size(); i++) step("tbl", i, tbl[i]);

    // Fence with three mem_busy cycles in the drain window
    fa_cycles = 0;
    step("fence_busy", 0, mk(F_FENCE,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW3));
    step("fence_busy", 1, mk(F_BUSY|F_FENCE,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW1|O_FA));
    step("fence_busy", 2, mk(F_BUSY|F_FENCE,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW1|O_FA));
    step("fence_busy", 3, mk(F_BUSY|F_FENCE,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW1|O_FA));
    step("fence_busy", 4, mk(F_FENCE,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW3));
    step("fence_busy", 5, mk(F_FENCE,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    step("fence_busy", 6, mk(8'h00,           5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    n_total++;
    if (fa_cycles == 5) n_pass++;
    else $display("FAIL fence_active_cycles: got %0d expected 5", fa_cycles);

    // Trap held off by mem_busy, then taken in the first free cycle
    step("trap_busy", 0, mk(F_BUSY|F_TRAP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW1));
    step("trap_busy", 1, mk(F_BUSY|F_TRAP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW1));
    step("trap_busy", 2, mk(F_TRAP,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, TRAPO|O_SEL2));
    step("trap_busy", 3, mk(8'h00,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_IFF));
    step("trap_busy", 4, mk(8'h00,         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));

    // Asynchronous reset in the middle of a drain abandons it
    step("rst_drain", 0, mk(F_FENCE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ROW3));
    drive(mk(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_drain", 1, RSTO);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rst_drain", 2, mk(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));

    // Reset during REDIRECT returns straight to RUN
    step("rst_redir", 0, mk(F_TRAP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, TRAPO|O_SEL2));
    drive(mk(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_redir", 1, RSTO);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rst_redir", 2, mk(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
